brick_field: RTL and testbench

Brick-map storage and collision/score unit for the breakout game. On each game tick it captures the ball position and direction and looks up the cell the ball is about to enter. If that cell holds a brick, it clears the brick, pulses `hit`, and increments a saturating 3-digit BCD score. It sits between the ball-movement stage and the matrix combiner/seven-segment path: it drives the `bricks` map and feeds the BCD digits straight to the seven-segment decoders.

---
 rtl/brick_field.sv | 160 ++++++++++++++++
 tb/tb_brick_field.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/brick_field.sv
// Breakout brick map with ball collision lookup and a saturating 3-digit BCD score.
// Each accepted tick runs IDLE -> LOOKUP -> APPLY; a reload discards any pending hit.
module brick_field #(
  parameter int BRICK_ROWS = 4,
  parameter int BRICK_COLS = 14,
  parameter int COL_OFFSET = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             new_game,
  input  logic                             next_level,
  input  logic [3:0]                       ball_rowIndex,
  input  logic [3:0]                       ball_colIndex,
  input  logic [3:0]                       ball_direction,
  output logic [BRICK_ROWS*BRICK_COLS-1:0] bricks,
  output logic [3:0]                       score100,
  output logic [3:0]                       score010,
  output logic [3:0]                       score001,
  output logic                             hit,
  output logic                             busy,
  output logic                             all_clear
);

  localparam int NB    = BRICK_ROWS * BRICK_COLS;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic signed [4:0] ROW_LIM = 5'(BRICK_ROWS);
  localparam logic signed [4:0] COL_LO  = 5'(COL_OFFSET);
  localparam logic signed [4:0] COL_HI  = 5'(COL_OFFSET + BRICK_COLS);

  typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;

  state_t            state, state_next;
  logic              reload;
  logic [3:0]        cap_row, cap_col, cap_dir;
  logic signed [4:0] dv, dh, tr, tc, tc_rel;
  logic              target_valid;
  int                idx_int;
  logic [IDX_W-1:0]  lookup_idx, tgt_idx;
  logic              hit_pending;
  logic              score_max;

  assign reload = new_game | next_level;

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (reload) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (tick) state_next = LOOKUP;
        LOOKUP:  state_next = APPLY;
        APPLY:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_row <= '0;
      cap_col <= '0;
      cap_dir <= '0;
    end else if (!reload && state == IDLE && tick) begin
      cap_row <= ball_rowIndex;
      cap_col <= ball_colIndex;
      cap_dir <= ball_direction;
    end
  end

  // Target cell in 5-bit signed arithmetic so row 0 moving up is -1, not 15.
  always_comb begin
    dv = 5'sd0;
    dh = 5'sd0;
    case (cap_dir[1:0])
      2'b01:   dv = -5'sd1;
      2'b10:   dv = 5'sd1;
      default: dv = 5'sd0;
    endcase
    case (cap_dir[3:2])
      2'b01:   dh = -5'sd1;
      2'b10:   dh = 5'sd1;
      default: dh = 5'sd0;
    endcase
    tr           = $signed({1'b0, cap_row}) + dv;
    tc           = $signed({1'b0, cap_col}) + dh;
    tc_rel       = tc - COL_LO;
    target_valid = (tr >= 5'sd0) && (tr < ROW_LIM) && (tc >= COL_LO) && (tc < COL_HI);
    idx_int      = int'(tr[3:0]) * BRICK_COLS + int'(tc_rel[3:0]);
    lookup_idx   = IDX_W'(idx_int);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tgt_idx     <= '0;
      hit_pending <= 1'b0;
    end else if (state == LOOKUP) begin
      tgt_idx     <= lookup_idx;
      hit_pending <= target_valid && bricks[lookup_idx];
    end
  end

  assign score_max = (score100 == 4'd9) && (score010 == 4'd9) && (score001 == 4'd9);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bricks   <= '1;
      score100 <= 4'd0;
      score010 <= 4'd0;
      score001 <= 4'd0;
      hit      <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (new_game) begin
        bricks   <= '1;
        score100 <= 4'd0;
        score010 <= 4'd0;
        score001 <= 4'd0;
      end else if (next_level) begin
        bricks <= '1;
      end else if (state == APPLY && hit_pending) begin
        bricks[tgt_idx] <= 1'b0;
        hit             <= 1'b1;
        // BCD ripple increment; holds at 999 while hits keep pulsing.
        if (!score_max) begin
          if (score001 != 4'd9) begin
            score001 <= score001 + 4'd1;
          end else begin
            score001 <= 4'd0;
            if (score010 != 4'd9) begin
              score010 <= score010 + 4'd1;
            end else begin
              score010 <= 4'd0;
              score100 <= score100 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) all_clear <= 1'b0;
    else        all_clear <= (bricks == '0);
  end

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: a cell-grid/integer-score model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_brick_field;

  localparam int ROWS = 4;
  localparam int COLS = 14;
  localparam int COFF = 1;
  localparam int NB   = ROWS * COLS;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0, new_game = 1'b0, next_level = 1'b0;
  logic [3:0]    ball_rowIndex = '0, ball_colIndex = '0, ball_direction = '0;
  logic [NB-1:0] bricks;
  logic [3:0]    score100, score010, score001;
  logic          hit, busy, all_clear;

  int errors = 0;
  int checks = 0;
  int dut_hits = 0;

  brick_field #(.BRICK_ROWS(ROWS), .BRICK_COLS(COLS), .COL_OFFSET(COFF)) dut (
    .clock(clock), .reset(reset), .tick(tick), .new_game(new_game), .next_level(next_level),
    .ball_rowIndex(ball_rowIndex), .ball_colIndex(ball_colIndex), .ball_direction(ball_direction),
    .bricks(bricks), .score100(score100), .score010(score010), .score001(score001),
    .hit(hit), .busy(busy), .all_clear(all_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: grid of present bricks, integer score, and a countdown of cycles the
  // unit stays occupied after accepting a tick.
  logic [NB-1:0] m_bricks;
  int            m_score, busy_left, m_idx;
  bit            m_hit, m_all_clear, m_will_hit;

  always @(posedge clock or negedge reset) begin
    logic [NB-1:0] prev;
    int tr, tc;
    if (!reset) begin
      m_bricks = '1; m_score = 0; m_hit = 0; m_all_clear = 0; busy_left = 0; m_will_hit = 0;
    end else begin
      prev  = m_bricks;
      m_hit = 0;
      if (new_game) begin
        m_bricks = '1; m_score = 0; busy_left = 0;
      end else if (next_level) begin
        m_bricks = '1; busy_left = 0;
      end else if (busy_left == 0) begin
        if (tick) begin
          tr = int'(ball_rowIndex) + (ball_direction[1:0] == 2'b01 ? -1 : ball_direction[1:0] == 2'b10 ? 1 : 0);
          tc = int'(ball_colIndex) + (ball_direction[3:2] == 2'b01 ? -1 : ball_direction[3:2] == 2'b10 ? 1 : 0);
          m_will_hit = 0;
          if (tr >= 0 && tr < ROWS && tc >= COFF && tc < COFF + COLS) begin
            m_idx = tr * COLS + tc - COFF;
            m_will_hit = m_bricks[m_idx];
          end
          busy_left = 2;
        end
      end else begin
        busy_left--;
        if (busy_left == 0 && m_will_hit) begin
          m_bricks[m_idx] = 1'b0;
          m_hit = 1;
          if (m_score < 999) m_score++;
        end
      end
      m_all_clear = (prev == '0);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("bricks", 64'(bricks), 64'(m_bricks));
      check("score", {52'd0, score100, score010, score001},
            {52'd0, 4'(m_score / 100), 4'(m_score / 10 % 10), 4'(m_score % 10)});
      check("hit", 64'(hit), 64'(m_hit));
      check("busy", 64'(busy), 64'(busy_left != 0));
      check("all_clear", 64'(all_clear), 64'(m_all_clear));
      if (hit) dut_hits++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Issue one tick and return 2 after E2, i.e. during the cycle where hit shows.
  task automatic do_tick(input int r, input int c, input logic [3:0] d);
    ball_rowIndex = 4'(r); ball_colIndex = 4'(c); ball_direction = d; tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1; cyc(1); new_game = 1'b0;
  endtask

  task automatic pulse_next_level();
    next_level = 1'b1; cyc(1); next_level = 1'b0;
  endtask

  task automatic clear_field();
    for (int r = 0; r < ROWS; r++)
      for (int c = COFF; c < COFF + COLS; c++) do_tick(r, c, 4'b0000);
  endtask

  initial begin
    int h;
    logic [NB-1:0] ones;
    ones = '1;
    #12 reset = 1'b1;
    cyc(1);

    // Upward hit: (1,5) up -> (0,5) -> bit 4
    do_tick(1, 5, 4'b0001);
    check("up_hit_pulse", 64'(hit), 64'd1);
    check("up_hit_brick4", 64'(bricks[4]), 64'd0);
    check("up_hit_score", {52'd0, score100, score010, score001}, 64'h001);
    do_tick(1, 5, 4'b0001);
    check("repeat_no_hit", 64'(hit), 64'd0);
    check("repeat_score", {52'd0, score100, score010, score001}, 64'h001);

    // Asynchronous reset in the middle of LOOKUP
    ball_rowIndex = 4'd1; ball_colIndex = 4'd6; ball_direction = 4'b0001; tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_bricks", 64'(bricks), 64'h00FF_FFFF_FFFF_FFFF);
    check("rst_score", {52'd0, score100, score010, score001}, 64'h000);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_all_clear", 64'(all_clear), 64'd0);
    #10 reset = 1'b1;
    cyc(1);

    // Diagonal out of range and row underflow
    do_tick(1, 14, 4'b1001);
    check("diag_oob_bricks", 64'(bricks), 64'(ones));
    check("diag_oob_hit", 64'(hit), 64'd0);
    do_tick(0, 3, 4'b0001);
    check("underflow_bricks", 64'(bricks), 64'(ones));
    check("underflow_hit", 64'(hit), 64'd0);
    cyc(1);

    // Second tick one cycle after the first is dropped
    h = dut_hits;
    ball_rowIndex = 4'd1; ball_colIndex = 4'd6; ball_direction = 4'b0001; tick = 1'b1;
    cyc(1);
    ball_colIndex = 4'd7;
    cyc(1);
    tick = 1'b0;
    cyc(4);
    check("busy_drop_hits", 64'(dut_hits - h), 64'd1);
    check("busy_drop_b5", 64'(bricks[5]), 64'd0);
    check("busy_drop_b6", 64'(bricks[6]), 64'd1);

    // Clear the whole field from a fresh game
    pulse_new_game();
    clear_field();
    check("last_hit_pulse", 64'(hit), 64'd1);
    check("clear_not_yet", 64'(all_clear), 64'd0);
    cyc(1);
    check("all_clear_set", 64'(all_clear), 64'd1);
    check("clear_score", {52'd0, score100, score010, score001}, 64'h056);
    pulse_next_level();
    check("next_level_bricks", 64'(bricks), 64'(ones));
    check("next_level_score", {52'd0, score100, score010, score001}, 64'h056);
    cyc(1);
    check("next_level_all_clear", 64'(all_clear), 64'd0);

    // Saturation over 18 levels
    pulse_new_game();
    h = dut_hits;
    for (int lvl = 0; lvl < 18; lvl++) begin
      clear_field();
      pulse_next_level();
    end
    cyc(2);
    check("sat_hits", 64'(dut_hits - h), 64'd1008);
    check("sat_score", {52'd0, score100, score010, score001}, 64'h999);

    // new_game together with tick: reload wins
    h = dut_hits;
    ball_rowIndex = 4'd1; ball_colIndex = 4'd5; ball_direction = 4'b0000;
    new_game = 1'b1; tick = 1'b1;
    cyc(1);
    new_game = 1'b0; tick = 1'b0;
    cyc(4);
    check("ng_tick_score", {52'd0, score100, score010, score001}, 64'h000);
    check("ng_tick_bricks", 64'(bricks), 64'(ones));
    check("ng_tick_hits", 64'(dut_hits - h), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
